// File: rtl/aes_ctr_pkg.sv
// Shared types and sizes for the AES-128 CTR sequencer and its IP top level.
package aes_ctr_pkg;

  localparam int AES_BLK_W    = 128;
  localparam int CTR_W_DEF    = 32;
  localparam int ENC_WAIT_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CALC = 2'd2,
    S_OUT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/aes_ctr_sequencer.sv
// Holds key/nonce/counter and drives the combinational AES core as an ENC_WAIT-cycle multicycle path.
// One block in flight: result is valid ENC_WAIT edges after the din handshake and holds until dout_ready.
module aes_ctr_sequencer
  import aes_ctr_pkg::*;
#(
  parameter int ENC_WAIT = ENC_WAIT_DEF,
  parameter int CTR_W    = CTR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_load,
  input  logic [AES_BLK_W-1:0]       cfg_key,
  input  logic [AES_BLK_W-CTR_W-1:0] cfg_nonce,
  input  logic [CTR_W-1:0]           cfg_ctr,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic [AES_BLK_W-1:0]       din_data,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [AES_BLK_W-1:0]       dout_data,
  output logic [AES_BLK_W-1:0]       enc_key,
  output logic [AES_BLK_W-1:0]       enc_state,
  output logic [AES_BLK_W-1:0]       enc_data,
  input  logic [AES_BLK_W-1:0]       enc_result,
  output logic                       ctr_wrap,
  output logic                       busy
);

  localparam int NONCE_W = AES_BLK_W - CTR_W;
  localparam int CNT_W   = $clog2(ENC_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ENC_WAIT - 1);

  seq_state_e             state_q, state_d;
  logic [AES_BLK_W-1:0]   key_q, key_d;
  logic [NONCE_W-1:0]     nonce_q, nonce_d;
  logic [CTR_W-1:0]       ctr_q, ctr_d;
  logic [AES_BLK_W-1:0]   enc_state_q, enc_state_d;
  logic [AES_BLK_W-1:0]   enc_data_q, enc_data_d;
  logic [AES_BLK_W-1:0]   dout_data_q, dout_data_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   din_ready_q, din_ready_d;
  logic                   ctr_wrap_q, ctr_wrap_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      nonce_q      <= '0;
      ctr_q        <= '0;
      enc_state_q  <= '0;
      enc_data_q   <= '0;
      dout_data_q  <= '0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b0;
      ctr_wrap_q   <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      ctr_q        <= ctr_d;
      enc_state_q  <= enc_state_d;
      enc_data_q   <= enc_data_d;
      dout_data_q  <= dout_data_d;
      dout_valid_q <= dout_valid_d;
      din_ready_q  <= din_ready_d;
      ctr_wrap_q   <= ctr_wrap_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    nonce_d      = nonce_q;
    ctr_d        = ctr_q;
    enc_state_d  = enc_state_q;
    enc_data_d   = enc_data_q;
    dout_data_d  = dout_data_q;
    dout_valid_d = dout_valid_q;
    ctr_wrap_d   = ctr_wrap_q;
    wait_cnt_d   = wait_cnt_q;

    // A reload aborts any in-flight block; its counter value is never consumed.
    if (cfg_load) begin
      key_d        = cfg_key;
      nonce_d      = cfg_nonce;
      ctr_d        = cfg_ctr;
      ctr_wrap_d   = 1'b0;
      dout_valid_d = 1'b0;
      wait_cnt_d   = '0;
      state_d      = S_WAIT;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (din_valid && din_ready_q) begin
            enc_data_d  = din_data;
            enc_state_d = {nonce_q, ctr_q};
            wait_cnt_d  = '0;
            state_d     = S_CALC;
          end
        end
        S_CALC: begin
          if (wait_cnt_q == WAIT_LAST) begin
            dout_data_d  = enc_result;
            dout_valid_d = 1'b1;
            ctr_d        = ctr_q + CTR_W'(1);
            if (&ctr_q) ctr_wrap_d = 1'b1;
            wait_cnt_d   = '0;
            state_d      = S_OUT;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
        S_OUT: begin
          if (dout_ready) begin
            dout_valid_d = 1'b0;
            state_d      = S_WAIT;
          end
        end
        default: ;
      endcase
    end

    // Registered ready: decided from next state so no din_valid/dout_ready path reaches it.
    din_ready_d = (state_d == S_WAIT) && !ctr_wrap_d;
  end

  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;
  assign enc_key    = key_q;
  assign enc_state  = enc_state_q;
  assign enc_data   = enc_data_q;
  assign ctr_wrap   = ctr_wrap_q;
  assign busy       = (state_q == S_CALC) || (state_q == S_OUT);

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Directed bench for aes_ctr_sequencer with a behavioural stand-in for the AES core.
module tb_aes_ctr_sequencer;

  localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [95:0]  NONCE = 96'hf0f1f2f3f4f5f6f7f8f9fafb;
  localparam logic [127:0] KS1   = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
  localparam logic [127:0] KS2   = 128'h362b7c3c6773516318a077d7fc5073ae;
  localparam logic [127:0] P1    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1    = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] C2    = 128'h9806f66b7970fdff8617187bb9fffdff;

  logic         clk, rst_n, cfg_load;
  logic [127:0] cfg_key;
  logic [95:0]  cfg_nonce;
  logic [31:0]  cfg_ctr;
  logic         din_valid, din_ready, dout_valid, dout_ready;
  logic [127:0] din_data, dout_data, enc_key, enc_state, enc_data, enc_result;
  logic         ctr_wrap, busy;
  int           total, bad;

  aes_ctr_sequencer #(.ENC_WAIT(2), .CTR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_key(cfg_key),
    .cfg_nonce(cfg_nonce), .cfg_ctr(cfg_ctr), .din_valid(din_valid),
    .din_ready(din_ready), .din_data(din_data), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_data(dout_data), .enc_key(enc_key),
    .enc_state(enc_state), .enc_data(enc_data), .enc_result(enc_result),
    .ctr_wrap(ctr_wrap), .busy(busy)
  );

  // Known SP800-38A keystream blocks; anything else gets a deterministic stand-in.
  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] s,
                                          input logic [127:0] d);
    logic [127:0] ks;
    if (k == KEY && s == {NONCE, 32'hfcfdfeff})      ks = KS1;
    else if (k == KEY && s == {NONCE, 32'hfcfdff00}) ks = KS2;
    else ks = s ^ {k[63:0], k[127:64]} ^ 128'h0123456789abcdef_fedcba9876543210;
    return ks ^ d;
  endfunction

  assign enc_result = core_f(enc_key, enc_state, enc_data);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [31:0] ctr);
    cfg_key   = KEY;
    cfg_nonce = NONCE;
    cfg_ctr   = ctr;
    cfg_load  = 1'b1;
    tick();
    cfg_load  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_load = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    cfg_key = '0; cfg_nonce = '0; cfg_ctr = '0; din_data = '0;
    #23;
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL reset_din_ready got=%h want=0", din_ready); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid got=%h want=0", dout_valid); end
    total++; if (dout_data !== '0) begin bad++; $display("FAIL reset_dout_data got=%h want=0", dout_data); end
    total++; if ({enc_key, enc_state, enc_data} !== '0) begin bad++; $display("FAIL reset_enc got=%h/%h/%h want=0", enc_key, enc_state, enc_data); end
    total++; if ({ctr_wrap, busy} !== 2'b00) begin bad++; $display("FAIL reset_wrap_busy got=%b want=00", {ctr_wrap, busy}); end
    rst_n = 1'b1;
    din_valid = 1'b1; din_data = P1;
    tick(); tick(); tick();
    total++; if (din_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_no_accept got rdy=%b busy=%b want 0/0", din_ready, busy); end
    din_valid = 1'b0;
  endtask

  task automatic test_vector_latency();
    dout_ready = 1'b1;
    do_cfg(32'hfcfdfeff);
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL cfg_din_ready got=%b want=1", din_ready); end
    din_valid = 1'b1; din_data = P1;
    tick();  // E0
    din_valid = 1'b0;
    total++; if (enc_state !== {NONCE, 32'hfcfdfeff} || enc_data !== P1) begin bad++; $display("FAIL vec1_enc got=%h/%h want=%h/%h", enc_state, enc_data, {NONCE, 32'hfcfdfeff}, P1); end
    total++; if (din_ready !== 1'b0 || busy !== 1'b1 || dout_valid !== 1'b0) begin bad++; $display("FAIL e0_flags got rdy=%b busy=%b vld=%b want 0/1/0", din_ready, busy, dout_valid); end
    tick();  // E1
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL e1_dout_valid got=%b want=0", dout_valid); end
    tick();  // E2
    total++; if (dout_valid !== 1'b1 || dout_data !== C1) begin bad++; $display("FAIL vec1_dout got vld=%b %h want 1 %h", dout_valid, dout_data, C1); end
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL e2_din_ready got=%b want=0", din_ready); end
    tick();  // E3: dout handshake
    total++; if (dout_valid !== 1'b0 || din_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL e3_flags got vld=%b rdy=%b busy=%b want 0/1/0", dout_valid, din_ready, busy); end
    din_valid = 1'b1; din_data = P2;
    tick();  // E4: back-to-back handshake
    din_valid = 1'b0;
    total++; if (enc_state !== {NONCE, 32'hfcfdff00}) begin bad++; $display("FAIL vec2_enc_state got=%h want=%h", enc_state, {NONCE, 32'hfcfdff00}); end
    tick(); tick();
    total++; if (dout_valid !== 1'b1 || dout_data !== C2) begin bad++; $display("FAIL vec2_dout got vld=%b %h want 1 %h", dout_valid, dout_data, C2); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [127:0] d, exp;
    d = 128'h00112233445566778899aabbccddeeff;
    exp = core_f(KEY, {NONCE, 32'h00000010}, d);
    dout_ready = 1'b0;
    do_cfg(32'h00000010);
    din_valid = 1'b1; din_data = d;
    tick();
    din_data = ~d;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (dout_valid !== 1'b1 || dout_data !== exp || din_ready !== 1'b0 ||
          enc_state !== {NONCE, 32'h00000010} || enc_data !== d || enc_key !== KEY) begin
        bad++;
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b dout=%h st=%h want 1/0 %h %h", i, dout_valid, din_ready, dout_data, enc_state, exp, {NONCE, 32'h00000010});
      end
      tick();
    end
    din_valid = 1'b0; dout_ready = 1'b1;
    tick();
    total++; if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin bad++; $display("FAIL bp_release got vld=%b rdy=%b want 0/1", dout_valid, din_ready); end
  endtask

  task automatic test_wrap();
    logic [127:0] d;
    d = 128'hcafef00d_deadbeef_01020304_a5a5a5a5;
    dout_ready = 1'b1;
    do_cfg(32'hffffffff);
    din_valid = 1'b1; din_data = d;
    tick();
    total++; if (enc_state[31:0] !== 32'hffffffff) begin bad++; $display("FAIL wrap_enc_state got=%h want=ffffffff", enc_state[31:0]); end
    tick(); tick();
    total++; if (dout_valid !== 1'b1 || ctr_wrap !== 1'b1 || dout_data !== core_f(KEY, {NONCE, 32'hffffffff}, d)) begin bad++; $display("FAIL wrap_capture got vld=%b wrap=%b dout=%h", dout_valid, ctr_wrap, dout_data); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (din_ready !== 1'b0 || ctr_wrap !== 1'b1 || busy !== 1'b0 || dout_valid !== 1'b0 || enc_state[31:0] !== 32'hffffffff) begin
        bad++;
        $display("FAIL wrap_halt[%0d] got rdy=%b wrap=%b busy=%b vld=%b ctr=%h want 0/1/0/0 ffffffff", i, din_ready, ctr_wrap, busy, dout_valid, enc_state[31:0]);
      end
    end
    din_valid = 1'b0;
    do_cfg(32'h00000020);
    total++; if (ctr_wrap !== 1'b0 || din_ready !== 1'b1) begin bad++; $display("FAIL wrap_clear got wrap=%b rdy=%b want 0/1", ctr_wrap, din_ready); end
  endtask

  task automatic test_abort();
    logic [127:0] d2;
    d2 = 128'h55555555_aaaaaaaa_12345678_9abcdef0;
    dout_ready = 1'b1;
    do_cfg(32'h00000001);
    din_valid = 1'b1; din_data = 128'h1;
    tick();  // block enters CALC
    din_valid = 1'b0;
    do_cfg(32'h00000005);
    total++; if (dout_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin bad++; $display("FAIL abort_state got vld=%b busy=%b rdy=%b want 0/0/1", dout_valid, busy, din_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL abort_no_dout[%0d] got=%b want=0", i, dout_valid); end
    end
    din_valid = 1'b1; din_data = d2;
    tick();
    din_valid = 1'b0;
    total++; if (enc_state[31:0] !== 32'h00000005) begin bad++; $display("FAIL abort_next_ctr got=%h want=00000005", enc_state[31:0]); end
    tick(); tick();
    total++; if (dout_valid !== 1'b1 || dout_data !== core_f(KEY, {NONCE, 32'h00000005}, d2)) begin bad++; $display("FAIL abort_next_dout got vld=%b %h", dout_valid, dout_data); end
    tick();
  endtask

  task automatic test_reset_mid_block();
    dout_ready = 1'b0;
    do_cfg(32'h00000040);
    din_valid = 1'b1; din_data = 128'h77;
    tick();
    din_valid = 1'b0;
    tick(); tick();
    total++; if (dout_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rst_pre got vld=%b busy=%b want 1/1", dout_valid, busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (dout_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b0 || dout_data !== '0) begin bad++; $display("FAIL rst_async got vld=%b busy=%b rdy=%b dout=%h want 0/0/0/0", dout_valid, busy, din_ready, dout_data); end
    #14 rst_n = 1'b1;
    din_valid = 1'b1; dout_ready = 1'b1;
    tick(); tick(); tick();
    total++; if (din_ready !== 1'b0 || dout_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_idle got rdy=%b vld=%b busy=%b want 0/0/0", din_ready, dout_valid, busy); end
    din_valid = 1'b0;
    do_cfg(32'h00000000);
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL rst_cfg_ready got=%b want=1", din_ready); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_vector_latency();
    test_backpressure();
    test_wrap();
    test_abort();
    test_reset_mid_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
